// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient}.
// Handles signed and unsigned operands. The operation can be annulled at any point.
module div (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [64:0] work_q;      // {partial remainder[32:0], dividend/quotient[31:0]}
  logic [31:0] divisor_q;
  logic        quot_neg_q;
  logic        rem_neg_q;
  logic [63:0] result_q;
  logic        ready_q;
  logic        busy_q;

  logic [31:0] op1_abs, op2_abs;
  logic [33:0] trial;
  logic [64:0] work_d;
  logic [31:0] quot_fix, rem_fix;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    op1_abs = opdata1;
    op2_abs = opdata2;
    if (signed_div && opdata1[31]) op1_abs = -opdata1;
    if (signed_div && opdata2[31]) op2_abs = -opdata2;

    // Shift left by one and trial-subtract in a single step. Bit 33 is the borrow.
    trial  = work_q[64:31] - {2'b00, divisor_q};
    work_d = trial[33] ? {work_q[63:0], 1'b0}
                       : {trial[32:0], work_q[30:0], 1'b1};

    quot_fix = quot_neg_q ? -work_q[31:0]  : work_q[31:0];
    rem_fix  = rem_neg_q  ? -work_q[63:32] : work_q[63:32];
  end

  // NOTE: state is updated only with non-blocking assignments. All branches then see the pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !annul) begin
            quot_neg_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            rem_neg_q  <= signed_div & opdata1[31];
            divisor_q  <= op2_abs;
            work_q     <= {33'd0, op1_abs};
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= (opdata2 == 32'd0) ? S_BY_ZERO : S_ON;
          end
        end
        S_BY_ZERO: begin
          busy_q <= 1'b0;
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            work_q  <= '0;
            state_q <= S_END;
          end
        end
        S_ON: begin
          if (annul) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              busy_q  <= 1'b0;
              state_q <= S_END;
            end
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          if (!annul) begin
            result_q <= {rem_fix, quot_fix};
            ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_div.sv
// Directed testbench for div: table of divide vectors plus annul/reset/start-hold sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[12];

  div dut (
    .clk       (clk),
    .resetn    (resetn),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issue one divide, then scramble the operand inputs. Wait at most 40 cycles for ready.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_start, output logic [63:0] res,
                         output int lat, output int busy_n, output bit held);
    logic [63:0] prev;
    prev = result;
    @(negedge clk);
    signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    signed_div = ~sgn; opdata1 = ~a; opdata2 = b + 32'd3;
    lat = -1; busy_n = 0; held = 1'b1; res = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b0;
      if (busy) busy_n++;
      if (ready) begin
        lat = k;
        res = result;
        break;
      end
      if (result !== prev) held = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic apply_vec(input string name, input vec_t v, input bit hold_start);
    logic [63:0] res;
    int          lat, busy_n;
    bit          held;
    run_div(v.sgn, v.a, v.b, hold_start, res, lat, busy_n, held);
    check({name, "_result"}, res, {v.r, v.q});
    check({name, "_latency"}, 64'(lat), 64'(v.lat));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(v.busy_n));
    check({name, "_result_held"}, 64'(held), 64'd1);
    check({name, "_busy_at_ready"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_ready_pulse"}, 64'(ready), 64'd0);
  endtask

  task automatic watch_no_ready(input string name, input int n, input logic [63:0] prev);
    bit seen;
    bit changed;
    seen = 1'b0;
    changed = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
      if (result !== prev) changed = 1'b1;
    end
    check({name, "_no_ready"}, 64'(seen), 64'd0);
    check({name, "_result_kept"}, 64'(changed), 64'd0);
  endtask

  initial begin
    logic [63:0] prev;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 32};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33, 32};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33, 32};
    vecs[3]  = '{1'b0, 32'd1234,       32'd0,          32'd0,          32'd0,           2,  1};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33, 32};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33, 32};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   33, 32};
    vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   33, 32};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          33, 32};
    vecs[9]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'd0,          32'd0,           2,  1};
    vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          33, 32};
    vecs[11] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          33, 32};

    #12;
    check("reset_result", result, 64'h0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) apply_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    // Annul during the 10th ON cycle, then start a new divide.
    prev = result;
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 9; k++) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_on_busy", 64'(busy), 64'd0);
    check("annul_on_ready", 64'(ready), 64'd0);
    check("annul_on_result", result, prev);
    apply_vec("after_annul_9div3", '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 32}, 1'b0);

    // Annul while in BY_ZERO.
    prev = result;
    @(negedge clk);
    opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("byzero_busy", 64'(busy), 64'd1);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_byzero_busy", 64'(busy), 64'd0);
    watch_no_ready("annul_byzero", 4, prev);

    // Annul while in END: no pulse and no result update.
    prev = result;
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 32; k++) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    check("annul_end_ready", 64'(ready), 64'd0);
    check("annul_end_result", result, prev);
    watch_no_ready("annul_end", 3, prev);

    // In IDLE, annul must win over start.
    prev = result;
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("annul_priority_busy", 64'(busy), 64'd0);
    watch_no_ready("annul_priority", 36, prev);

    // Hold start high while busy and change the operands mid-operation.
    apply_vec("start_held", vecs[0], 1'b1);

    // Pulse reset in the middle of ON.
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_result", result, 64'h0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_ready", 64'(ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    watch_no_ready("midreset", 36, 64'h0);
    apply_vec("post_reset", vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
